// File: rtl/matmul_sequencer_pkg.sv
// Shared types and constants for the matmul start/done sequencer.
// The state encoding is shared so every file agrees on it.
package matmul_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam state_t RESET_STATE = ST_IDLE;
    localparam logic   RESET_OUT   = 1'b0;

    localparam int NUM_OPERANDS = 2;
    localparam int OPERAND_A    = 0;
    localparam int OPERAND_B    = 1;

    // The skew of the systolic array takes 2*N-1 cycles to flush.
    function automatic int drain_cycles(input int mat_size);
        return 2 * mat_size - 1;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_CLEAR) || (s == ST_FEED) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Operand address generator: loads base and stride, then adds the stride
// once per step. The sum wraps naturally at the address width.
module matmul_addr_gen
    import matmul_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] stride_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] stride_next;

    always_comb begin
        addr_next   = addr_reg;
        stride_next = stride_reg;
        if (load) begin
            addr_next   = base;
            stride_next = stride;
        end else if (step) begin
            addr_next = addr_reg + stride_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            stride_reg <= '0;
        end else begin
            addr_reg   <= addr_next;
            stride_reg <= stride_next;
        end
    end

    assign addr = addr_reg;

endmodule

// File: rtl/matmul_sequencer.sv
// Responder side of the controller start/done handshake: clears the array,
// streams A/B operand addresses over K, waits out the skew, then reports done.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int MAT_SIZE   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_mat_mul,
    input  logic [ADDR_WIDTH-1:0] address_mat_a,
    input  logic [ADDR_WIDTH-1:0] address_mat_b,
    input  logic [ADDR_WIDTH-1:0] address_stride_a,
    input  logic [ADDR_WIDTH-1:0] address_stride_b,
    input  logic [CNT_WIDTH-1:0]  num_k,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_en,
    output logic                  clear_acc,
    output logic                  busy,
    output logic                  done_mat_mul
);

    localparam int DRAIN_CYCLES = drain_cycles(MAT_SIZE);
    localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   k_reg, k_next;
    logic [CNT_WIDTH-1:0]   num_k_reg, num_k_next;
    logic [DRAIN_W-1:0]     drain_reg, drain_next;
    logic                   addr_load;
    logic                   addr_step;

    logic                   clear_acc_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // Next-state logic. Withdrawing the request aborts any active phase.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        num_k_next = num_k_reg;
        drain_next = drain_reg;
        addr_load  = 1'b0;
        addr_step  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_mat_mul) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!start_mat_mul) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_FEED;
                    addr_load  = 1'b1;
                    k_next     = '0;
                    num_k_next = (num_k == '0) ? CNT_ONE : num_k;
                end
            end
            ST_FEED: begin
                if (!start_mat_mul) begin
                    state_next = ST_IDLE;
                end else if (k_reg == num_k_reg - CNT_ONE) begin
                    state_next = ST_DRAIN;
                    drain_next = '0;
                end else begin
                    k_next    = k_reg + CNT_ONE;
                    addr_step = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!start_mat_mul) begin
                    state_next = ST_IDLE;
                end else if (drain_reg == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    drain_next = drain_reg + DRAIN_ONE;
                end
            end
            ST_DONE: begin
                // Only a withdrawn request leaves DONE, so a held request cannot re-run.
                if (!start_mat_mul) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RESET_STATE;
            k_reg         <= '0;
            num_k_reg     <= '0;
            drain_reg     <= '0;
            clear_acc_reg <= RESET_OUT;
            busy_reg      <= RESET_OUT;
            done_reg      <= RESET_OUT;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            num_k_reg     <= num_k_next;
            drain_reg     <= drain_next;
            clear_acc_reg <= (state_next == ST_CLEAR);
            busy_reg      <= is_busy(state_next);
            done_reg      <= (state_next == ST_DONE);
        end
    end

    logic [ADDR_WIDTH-1:0] base_sel   [NUM_OPERANDS];
    logic [ADDR_WIDTH-1:0] stride_sel [NUM_OPERANDS];
    logic [ADDR_WIDTH-1:0] addr_out   [NUM_OPERANDS];
    logic                  en_out     [NUM_OPERANDS];

    assign base_sel[OPERAND_A]   = address_mat_a;
    assign base_sel[OPERAND_B]   = address_mat_b;
    assign stride_sel[OPERAND_A] = address_stride_a;
    assign stride_sel[OPERAND_B] = address_stride_b;

    for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_operand
        logic en_reg;

        matmul_addr_gen #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_addr_gen (
            .clk    (clk),
            .reset  (reset),
            .load   (addr_load),
            .step   (addr_step),
            .base   (base_sel[gi]),
            .stride (stride_sel[gi]),
            .addr   (addr_out[gi])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                en_reg <= RESET_OUT;
            end else begin
                en_reg <= (state_next == ST_FEED);
            end
        end

        assign en_out[gi] = en_reg;
    end

    assign a_addr       = addr_out[OPERAND_A];
    assign b_addr       = addr_out[OPERAND_B];
    assign a_en         = en_out[OPERAND_A];
    assign b_en         = en_out[OPERAND_B];
    assign clear_acc    = clear_acc_reg;
    assign busy         = busy_reg;
    assign done_mat_mul = done_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: stimulus pushes expected events
// (clear pulse, operand addresses, done rise) and a monitor pops and compares.
module tb_matmul_sequencer;

    localparam int MS = 4;
    localparam int AW = 10;
    localparam int CW = 8;

    localparam int EV_CLEAR = 0;
    localparam int EV_FEED  = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_mat_mul;
    logic [AW-1:0] address_mat_a, address_mat_b;
    logic [AW-1:0] address_stride_a, address_stride_b;
    logic [CW-1:0] num_k;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_en, b_en, clear_acc, busy, done_mat_mul;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    ev_t exp_q[$];
    logic done_prev = 1'b0;

    matmul_sequencer #(
        .MAT_SIZE   (MS),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_mat_mul    (start_mat_mul),
        .address_mat_a    (address_mat_a),
        .address_mat_b    (address_mat_b),
        .address_stride_a (address_stride_a),
        .address_stride_b (address_stride_b),
        .num_k            (num_k),
        .a_addr           (a_addr),
        .a_en             (a_en),
        .b_addr           (b_addr),
        .b_en             (b_en),
        .clear_acc        (clear_acc),
        .busy             (busy),
        .done_mat_mul     (done_mat_mul)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [AW-1:0] a, input logic [AW-1:0] b);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic [AW-1:0] a, input logic [AW-1:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d got=event exp=none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == EV_FEED && e.kind == EV_FEED) begin
                chk("a_addr", a, e.a);
                chk("b_addr", b, e.b);
            end
        end
    endtask

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (clear_acc) check_event(EV_CLEAR, a_addr, b_addr);
            if (a_en) check_event(EV_FEED, a_addr, b_addr);
            if (done_mat_mul && !done_prev) check_event(EV_DONE, a_addr, b_addr);
            if (a_en || b_en) chk("b_en_eq_a_en", b_en, a_en);
            if (clear_acc || a_en) chk("busy_active", busy, 1);
            if (done_mat_mul) chk("busy_in_done", busy, 0);
        end
        done_prev <= done_mat_mul;
    end

    task automatic scramble_inputs();
        address_mat_a    = AW'($urandom);
        address_mat_b    = AW'($urandom);
        address_stride_a = AW'($urandom);
        address_stride_b = AW'($urandom);
        num_k            = CW'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_addr"}, a_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_a_en"}, a_en, 0);
        chk({tag, "_b_en"}, b_en, 0);
        chk({tag, "_clear_acc"}, clear_acc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done_mat_mul, 0);
    endtask

    // Full run; the controller releases start `hold` cycles after the edge it sees done.
    task automatic do_run(input logic [AW-1:0] ba, input logic [AW-1:0] sa,
                          input logic [AW-1:0] bb, input logic [AW-1:0] sb,
                          input logic [CW-1:0] nk, input int hold, input bit scramble);
        int s, eff, t, lat;
        @(posedge clk); #1;
        s   = cyc;
        eff = (nk == 0) ? 1 : int'(nk);
        lat = eff + 2 * MS + 1;
        push_ev(EV_CLEAR, s + 1, '0, '0);
        for (int k = 0; k < eff; k++) begin
            push_ev(EV_FEED, s + 2 + k, AW'(int'(ba) + k * int'(sa)), AW'(int'(bb) + k * int'(sb)));
        end
        push_ev(EV_DONE, s + lat, '0, '0);
        address_mat_a    = ba;
        address_stride_a = sa;
        address_mat_b    = bb;
        address_stride_b = sb;
        num_k            = nk;
        reset            = 1'b0;
        start_mat_mul    = 1'b1;
        t = 0;
        while (done_mat_mul !== 1'b1 && t < lat + 20) begin
            @(posedge clk); #1;
            t++;
            if (scramble && cyc >= s + 2) scramble_inputs();
        end
        if (done_mat_mul !== 1'b1) begin
            chk("done_timeout", done_mat_mul, 1);
            exp_q.delete();
        end else begin
            chk("done_latency", cyc - s, lat);
        end
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            chk("done_held", done_mat_mul, 1);
        end
        start_mat_mul = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", done_mat_mul, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("run ba=%03h sa=%03h bb=%03h sb=%03h nk=%0d hold=%0d start_cyc=%0d", ba, sa, bb, sb, nk, hold, s);
    endtask

    task automatic abort_in_feed();
        int s;
        @(posedge clk); #1;
        s = cyc;
        push_ev(EV_CLEAR, s + 1, '0, '0);
        for (int k = 0; k < 3; k++) push_ev(EV_FEED, s + 2 + k, AW'(32 + k * 2), AW'(64 + k * 5));
        address_mat_a = 10'd32; address_stride_a = 10'd2;
        address_mat_b = 10'd64; address_stride_b = 10'd5;
        num_k = 8'd6;
        start_mat_mul = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start_mat_mul = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_a_en", a_en, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done_mat_mul, 0);
        end
        chk("abort_queue", exp_q.size(), 0);
        $display("abort in FEED start_cyc=%0d", s);
    endtask

    task automatic reset_in_drain();
        int s;
        @(posedge clk); #1;
        s = cyc;
        push_ev(EV_CLEAR, s + 1, '0, '0);
        for (int k = 0; k < 3; k++) push_ev(EV_FEED, s + 2 + k, AW'(5 + k * 7), AW'(9 + k * 11));
        address_mat_a = 10'd5; address_stride_a = 10'd7;
        address_mat_b = 10'd9; address_stride_b = 10'd11;
        num_k = 8'd3;
        start_mat_mul = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        chk("reset_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        check_all_zero("held_reset");
        $display("async reset in DRAIN start_cyc=%0d", s);
    endtask

    initial begin
        reset = 1'b1;
        start_mat_mul = 1'b0;
        address_mat_a = '0; address_mat_b = '0;
        address_stride_a = '0; address_stride_b = '0;
        num_k = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;

        do_run(10'h010, 10'h001, 10'h100, 10'h004, 8'd4, 0, 1'b0);
        do_run(10'h020, 10'h003, 10'h040, 10'h002, 8'd0, 0, 1'b0);
        do_run(10'h3FE, 10'h001, 10'h3F0, 10'h008, 8'd4, 0, 1'b1);
        abort_in_feed();
        do_run(10'h011, 10'h002, 10'h222, 10'h010, 8'd5, 0, 1'b0);
        do_run(10'h001, 10'h001, 10'h002, 10'h002, 8'd2, 5, 1'b0);
        reset_in_drain();
        do_run(10'h0AA, 10'h005, 10'h155, 10'h3FF, 8'd3, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_run(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                   CW'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
